// File: rtl/rob_pkg.sv
// Shared types and sizing for the ROB completion tracker.
package rob_pkg;

    localparam int unsigned PACK_W = 4;
    localparam int unsigned PACKS  = 16;
    localparam int unsigned SLOTS  = 2;
    localparam int unsigned ROB_W  = PACK_W + 1;
    localparam int unsigned PTR_W  = PACK_W + 1;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned EVENTS = 4;

    typedef logic [PACK_W-1:0] pack_id_t;
    typedef logic [ROB_W-1:0]  rob_id_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [SLOTS-1:0]  slot_mask_t;

    // Exception record kept per pack: slot of the oldest faulting instruction and its code.
    typedef struct packed {
        logic              slot;
        logic [CODE_W-1:0] code;
    } excp_rec_t;

endpackage

// File: rtl/rob_completion_tracker.sv
// Tracks done/exception state of in-flight dispatch packs and presents the oldest
// fully completed pack to commit.
module rob_completion_tracker
    import rob_pkg::*;
(
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_i,
    input  logic              flush_i,
    input  logic              alloc_vld_i,
    input  logic [SLOTS-1:0]  alloc_mask_i,
    output logic              alloc_ready_o,
    output logic [PACK_W-1:0] alloc_pack_o,
    input  logic              alu0_complete_i,
    input  logic [ROB_W-1:0]  alu0_rob_id_i,
    input  logic              alu1_complete_i,
    input  logic [ROB_W-1:0]  alu1_rob_id_i,
    input  logic              mem_complete_i,
    input  logic [ROB_W-1:0]  mem_rob_id_i,
    input  logic              excp_valid_i,
    input  logic [ROB_W:0]    excp_rob_i,
    input  logic [CODE_W-1:0] excp_code_i,
    output logic              commit_vld_o,
    output logic [PACK_W-1:0] commit_pack_o,
    output logic [SLOTS-1:0]  commit_mask_o,
    output logic              commit_excp_o,
    output logic              commit_excp_slot_o,
    output logic [CODE_W-1:0] commit_excp_code_o,
    input  logic              commit_ack_i,
    output logic [PTR_W-1:0]  occupancy_o
);

    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    slot_mask_t valid_q [PACKS];
    slot_mask_t valid_d [PACKS];
    slot_mask_t done_q  [PACKS];
    slot_mask_t done_d  [PACKS];
    logic       excp_q  [PACKS];
    logic       excp_d  [PACKS];
    excp_rec_t  rec_q   [PACKS];
    excp_rec_t  rec_d   [PACKS];

    pack_id_t   head_idx;
    pack_id_t   tail_idx;
    logic       empty;
    logic       full;
    logic       commit_fire;
    logic       alloc_fire;
    pack_id_t   ex_pack;
    logic       ex_slot;
    logic       excp_rob_unused;
    rob_id_t    ev_id  [EVENTS];
    logic       ev_vld [EVENTS];

    assign head_idx        = head_q[PACK_W-1:0];
    assign tail_idx        = tail_q[PACK_W-1:0];
    assign empty           = (head_q == tail_q);
    assign full            = (head_idx == tail_idx) && (head_q[PACK_W] != tail_q[PACK_W]);
    assign ex_pack         = excp_rob_i[ROB_W-1:1];
    assign ex_slot         = excp_rob_i[0];
    assign excp_rob_unused = excp_rob_i[ROB_W];

    // Gather the four completion sources so they can be applied uniformly.
    assign ev_vld[0] = alu0_complete_i;
    assign ev_id[0]  = alu0_rob_id_i;
    assign ev_vld[1] = alu1_complete_i;
    assign ev_id[1]  = alu1_rob_id_i;
    assign ev_vld[2] = mem_complete_i;
    assign ev_id[2]  = mem_rob_id_i;
    assign ev_vld[3] = excp_valid_i;
    assign ev_id[3]  = excp_rob_i[ROB_W-1:0];

    // Head presentation is combinational from registered state only.
    assign commit_vld_o       = !empty && (&(done_q[head_idx] | ~valid_q[head_idx]));
    assign commit_pack_o      = head_idx;
    assign commit_mask_o      = valid_q[head_idx];
    assign commit_excp_o      = excp_q[head_idx];
    assign commit_excp_slot_o = rec_q[head_idx].slot;
    assign commit_excp_code_o = rec_q[head_idx].code;
    assign alloc_ready_o      = !full;
    assign alloc_pack_o       = tail_idx;
    assign occupancy_o        = tail_q - head_q;

    assign commit_fire = commit_ack_i && commit_vld_o;
    assign alloc_fire  = alloc_vld_i && !full;

    // Next state: completions/exception first, then head retire, then tail allocate,
    // so an entry freed and reused in the same cycle starts clean.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        excp_d  = excp_q;
        rec_d   = rec_q;

        for (int e = 0; e < int'(EVENTS); e++) begin
            if (ev_vld[e] && valid_q[ev_id[e][ROB_W-1:1]][ev_id[e][0]]) begin
                done_d[ev_id[e][ROB_W-1:1]][ev_id[e][0]] = 1'b1;
            end
        end

        if (excp_valid_i && valid_q[ex_pack][ex_slot]) begin
            if (!excp_q[ex_pack] || (ex_slot < rec_q[ex_pack].slot)) begin
                excp_d[ex_pack]     = 1'b1;
                rec_d[ex_pack].slot = ex_slot;
                rec_d[ex_pack].code = excp_code_i;
            end
        end

        if (commit_fire) begin
            valid_d[head_idx] = '0;
            done_d[head_idx]  = '0;
            excp_d[head_idx]  = 1'b0;
            rec_d[head_idx]   = '0;
            head_d            = head_q + PTR_W'(1);
        end

        if (alloc_fire) begin
            valid_d[tail_idx] = alloc_mask_i;
            done_d[tail_idx]  = ~alloc_mask_i;
            excp_d[tail_idx]  = 1'b0;
            rec_d[tail_idx]   = '0;
            tail_d            = tail_q + PTR_W'(1);
        end
    end

    // State registers; reset and flush both discard every tracked pack.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(PACKS); i++) begin
                valid_q[i] <= '0;
                done_q[i]  <= '0;
                excp_q[i]  <= 1'b0;
                rec_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            excp_q  <= excp_d;
            rec_q   <= rec_d;
        end
    end

endmodule
